// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and master FSM states
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } axi_master_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator with watchdog abort
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  // Width 1 keeps the counter legal when the watchdog is disabled.
  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

  axi_master_state_e state, state_next;
  logic              aw_done, w_done, aw_done_next, w_done_next;
  logic              cmd_ready_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_hit, busy;
  logic              accept, b_fire, r_fire, abort;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        resp_q;
  logic              timeout_q;

  assign busy   = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_DATA);
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd_cnt >= WD_LAST);

  assign cmd_ready   = cmd_ready_q;
  assign AWADDR      = addr_q;
  assign ARADDR      = addr_q;
  assign WDATA       = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  // State register, per-channel done flags, registered cmd_ready and watchdog counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready_q <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state       <= state_next;
      aw_done     <= aw_done_next;
      w_done      <= w_done_next;
      cmd_ready_q <= (state_next == IDLE);
      if (accept)
        wd_cnt <= '0;
      else if (busy && (wd_cnt != WD_LAST))
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Next state and state-decoded handshake outputs; completing a handshake beats the watchdog.
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    accept       = 1'b0;
    b_fire       = 1'b0;
    r_fire       = 1'b0;
    abort        = 1'b0;
    AWVALID      = 1'b0;
    WVALID       = 1'b0;
    BREADY       = 1'b0;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept       = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if (!aw_done && AWREADY) aw_done_next = 1'b1;
        if (!w_done && WREADY)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) begin
          state_next = WR_RESP;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          b_fire     = 1'b1;
          state_next = RSP;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RD_REQ: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          state_next = RD_DATA;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RD_DATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          r_fire     = 1'b1;
          state_next = RSP;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture and response registers; held steady while the response waits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        rdata_q   <= '0;
        resp_q    <= OKAY;
        timeout_q <= 1'b0;
      end
      if (b_fire) begin
        rdata_q <= '0;
        resp_q  <= BRESP;
      end
      if (r_fire) begin
        rdata_q <= RDATA;
        resp_q  <= RRESP;
      end
      if (abort) begin
        rdata_q   <= '0;
        resp_q    <= SLVERR;
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized self-checking bench with delay-programmable slave
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata, rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic [31:0] WDATA, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // slave configuration and state
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, rd_pend = 1'b0;
  logic [3:0]  aw_addr_l = '0, ar_addr_l = '0;
  logic [31:0] w_data_l = '0;
  logic [31:0] smem [4];
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID && (w_cnt >= w_dly);
  assign ARREADY = ARVALID && !ar_never && (ar_cnt >= ar_dly);

  always @(posedge ACLK) begin
    logic        aw_now, w_now, rd_now;
    logic [3:0]  a_now, r_addr;
    logic [31:0] d_now;
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; rd_pend <= 1'b0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
      for (int i = 0; i < 4; i++) smem[i] <= '0;
    end else begin
      aw_now = aw_got; a_now = aw_addr_l;
      if (AWVALID && AWREADY) begin
        aw_now = 1'b1; a_now = AWADDR;
        aw_got <= 1'b1; aw_addr_l <= AWADDR; aw_cnt <= 0; n_aw <= n_aw + 1;
      end else if (AWVALID) aw_cnt <= aw_cnt + 1;
      w_now = w_got; d_now = w_data_l;
      if (WVALID && WREADY) begin
        w_now = 1'b1; d_now = WDATA;
        w_got <= 1'b1; w_data_l <= WDATA; w_cnt <= 0; n_w <= n_w + 1;
      end else if (WVALID) w_cnt <= w_cnt + 1;
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; n_b <= n_b + 1;
      end else if (!BVALID && aw_now && w_now) begin
        if (b_cnt >= b_dly) begin
          BVALID <= 1'b1; BRESP <= b_resp_cfg; smem[a_now[3:2]] <= d_now;
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      rd_now = rd_pend; r_addr = ar_addr_l;
      if (ARVALID && ARREADY) begin
        rd_now = 1'b1; r_addr = ARADDR;
        rd_pend <= 1'b1; ar_addr_l <= ARADDR; ar_cnt <= 0; n_ar <= n_ar + 1;
      end else if (ARVALID) ar_cnt <= ar_cnt + 1;
      if (RVALID && RREADY) begin
        RVALID <= 1'b0; n_r <= n_r + 1;
      end else if (!RVALID && rd_now) begin
        if (r_cnt >= r_dly) begin
          RVALID <= 1'b1; RRESP <= r_resp_cfg; RDATA <= smem[r_addr[3:2]];
          rd_pend <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // cycle counters (negedge) and VALID-stability monitor (posedge)
  int         cyc_awv = 0, cyc_wv = 0, cyc_arv = 0, cyc_rr = 0, proto_err = 0;
  bit         allow_abort = 1'b0;
  logic       p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [3:0] p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;

  always @(negedge ACLK) begin
    if (AWVALID) cyc_awv++;
    if (WVALID)  cyc_wv++;
    if (ARVALID) cyc_arv++;
    if (RREADY)  cyc_rr++;
  end

  always @(posedge ACLK) begin
    if (!ARESET && !allow_abort) begin
      if (p_aw && !(AWVALID && AWADDR == p_awaddr)) proto_err++;
      if (p_w  && !(WVALID && WDATA == p_wdata))    proto_err++;
      if (p_ar && !(ARVALID && ARADDR == p_araddr)) proto_err++;
    end
    p_aw = !ARESET && AWVALID && !AWREADY; p_awaddr = AWADDR;
    p_w  = !ARESET && WVALID && !WREADY;   p_wdata  = WDATA;
    p_ar = !ARESET && ARVALID && !ARREADY; p_araddr = ARADDR;
  end

  logic [17:0] ctl_vec;
  assign ctl_vec = {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid,
                    rsp_timeout, rsp_resp, AWADDR, ARADDR};

  int          n_checks = 0, n_errors = 0;
  logic [31:0] mmem [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic wait_cmd_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    check_eq("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic [1:0] rs, output logic to, output int lat);
    int req0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    wait_cmd_ready();
    @(negedge ACLK);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(negedge ACLK); lat++; end
    check_eq("rsp_valid_seen", rsp_valid, 1'b1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    req0 = n_aw + n_ar;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_rdata", rsp_rdata, rd);
      check_eq("hold_cmd_ready", cmd_ready, 1'b0);
      check_eq("hold_no_new_req", n_aw + n_ar, req0);
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check_eq("rsp_consumed", rsp_valid, 1'b0);
    check_eq("idle_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic xact(input logic wr, input logic [3:0] a, input logic [31:0] d, input int hold);
    int          lat, exp_lat, aw0, w0, b0, ar0, r0;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    exp_lat = wr ? 3 + imax(aw_dly, w_dly) + b_dly : 3 + ar_dly + r_dly;
    do_cmd(wr, a, d, hold, rd, rs, to, lat);
    check_eq("latency", lat, exp_lat);
    check_eq("timeout_flag", to, 1'b0);
    if (wr) begin
      mmem[a[3:2]] = d;
      check_eq("wr_rdata", rd, 32'h0);
      check_eq("wr_resp", rs, b_resp_cfg);
      check_eq("wr_handshakes", {n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0}, {32'd1, 32'd1, 32'd1, 32'd0});
    end else begin
      check_eq("rd_rdata", rd, mmem[a[3:2]]);
      check_eq("rd_resp", rs, r_resp_cfg);
      check_eq("rd_handshakes", {n_ar - ar0, n_r - r0, n_aw - aw0}, {32'd1, 32'd1, 32'd0});
    end
  endtask

  task automatic zero_delays();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; ar_never = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    @(negedge ACLK);
  endtask

  initial begin
    int          c0, c1, c2, lat, n, seen;
    logic [31:0] rd, dat;
    logic [1:0]  rs;
    logic        to;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_eq("reset_ctl", ctl_vec, '0);
    check_eq("reset_data", {rsp_rdata, WDATA}, '0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("cmd_ready_after_reset", cmd_ready, 1'b1);

    // zero-wait write then read-back
    c0 = cyc_awv; c1 = cyc_wv;
    xact(1'b1, 4'h4, 32'hDEADBEEF, 0);
    check_eq("awaddr_0x4", aw_addr_l, 4'h4);
    check_eq("aw_w_one_cycle", {cyc_awv - c0, cyc_wv - c1}, {32'd1, 32'd1});
    check_eq("slave_reg1", smem[1], 32'hDEADBEEF);
    c0 = cyc_rr;
    xact(1'b0, 4'h4, 32'h0, 0);
    check_eq("araddr_0x4", ar_addr_l, 4'h4);
    check_eq("rready_one_cycle", cyc_rr - c0, 1);

    // W accepted three cycles before AW
    zero_delays(); aw_dly = 3;
    c0 = cyc_awv; c1 = cyc_wv;
    xact(1'b1, 4'h8, 32'h1234_5678, 0);
    check_eq("aw_held_w_dropped", {cyc_awv - c0, cyc_wv - c1}, {32'd4, 32'd1});
    check_eq("slave_reg2", smem[2], 32'h1234_5678);

    // read with response back-pressure
    zero_delays();
    xact(1'b0, 4'h8, 32'h0, 5);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      dat = $urandom;
      xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), dat, $urandom_range(0, 3));
    end
    zero_delays();

    // reset while WR_RESP waits on a delayed BVALID
    b_dly = 6;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFE_F00D;
    wait_cmd_ready();
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!BREADY && n < 20) begin @(negedge ACLK); n++; end
    check_eq("bready_pending", {BREADY, BVALID}, 2'b10);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("midreset_ctl", ctl_vec, '0);
    check_eq("midreset_data", {rsp_rdata, WDATA}, '0);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    @(negedge ACLK);
    check_eq("cmd_ready_after_midreset", cmd_ready, 1'b1);
    seen = 0;
    repeat (10) begin @(negedge ACLK); if (rsp_valid) seen++; end
    check_eq("no_rsp_after_reset", seen, 0);
    zero_delays();

    // watchdog: ARREADY never comes
    ar_never = 1'b1; allow_abort = 1'b1;
    c0 = cyc_arv; c2 = n_ar;
    do_cmd(1'b0, 4'h4, 32'h0, 0, rd, rs, to, lat);
    check_eq("timeout_latency", lat, 17);
    check_eq("timeout_resp", {to, rs}, 3'b110);
    check_eq("timeout_rdata", rd, 32'h0);
    check_eq("timeout_arvalid_cycles", cyc_arv - c0, 16);
    check_eq("timeout_no_ar_handshake", n_ar - c2, 0);
    check_eq("timeout_arvalid_low", ARVALID, 1'b0);
    do_reset();
    allow_abort = 1'b0;
    zero_delays();
    xact(1'b1, 4'h0, 32'h0BAD_CAFE, 1);
    xact(1'b0, 4'h0, 32'h0, 0);

    check_eq("valid_stability", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
